// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU engine.
package alu_pkg;

  // Supported alu_ctrl codes: {A_invert, B_invert, op[1:0]}
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_NAND = 4'b1101;

  // Slice operation select
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // ADD and LESS both ripple the carry through the slice
  function automatic logic is_add_class(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);

  logic a_eff;
  logic b_eff;
  logic sum;

  // Invert operands, form full-adder sum/carry, then pick the requested function
  always_comb begin
    a_eff = a ^ a_invert;
    b_eff = b ^ b_invert;
    sum   = a_eff ^ b_eff ^ cin;
    cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    unique case (op)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU engine: sequences one 1-bit slice LSB first over WIDTH cycles.
module serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Set once the MSB has been processed; the following cycle finalises the response
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             set_q, set_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic             slice_res;
  logic             slice_cout;
  logic             sum_msb;
  logic [WIDTH-1:0] final_res;

  alu_bit_slice u_slice (
    .a        (a_sr_q[0]),
    .b        (b_sr_q[0]),
    .less     (1'b0),
    .a_invert (ctrl_q[3]),
    .b_invert (ctrl_q[2]),
    .cin      (carry_q),
    .op       (ctrl_q[1:0]),
    .result   (slice_res),
    .cout     (slice_cout)
  );

  // Raw adder sum at the current bit, needed for the SLT sign decision at the MSB
  assign sum_msb = a_sr_q[0] ^ ctrl_q[3] ^ b_sr_q[0] ^ ctrl_q[2] ^ carry_q;

  // LESS drives zeros through the slice; only bit 0 carries the comparison outcome
  assign final_res = (ctrl_q[1:0] == OP_LESS) ? {{(WIDTH-1){1'b0}}, set_q} : res_sr_q;

  // Next-state logic: accept, shift one bit per cycle, finalise, hold until consumed
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fin_d      = fin_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    ctrl_d     = ctrl_q;
    carry_d    = carry_q;
    c_msb_d    = c_msb_q;
    set_d      = set_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sr_d  = src1;
          b_sr_d  = src2;
          ctrl_d  = alu_ctrl;
          // B_invert doubles as the +1 of two's-complement subtraction
          carry_d = alu_ctrl[2];
          cnt_d   = '0;
          fin_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!fin_q) begin
          a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
          res_sr_d = {slice_res, res_sr_q[WIDTH-1:1]};
          if (is_add_class(ctrl_q[1:0])) begin
            carry_d = slice_cout;
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            c_msb_d = carry_q;
            set_d   = sum_msb ^ carry_q ^ slice_cout;
            fin_d   = 1'b1;
          end
        end else begin
          result_d   = final_res;
          zero_d     = (final_res == '0);
          cout_d     = (ctrl_q[1:0] == OP_ADD) ? carry_q : 1'b0;
          overflow_d = (ctrl_q[1:0] == OP_ADD) ? (c_msb_q ^ carry_q) : 1'b0;
          fin_d      = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      c_msb_q    <= 1'b0;
      set_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      ctrl_q     <= ctrl_d;
      carry_q    <= carry_d;
      c_msb_q    <= c_msb_d;
      set_q      <= set_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_alu.sv
// Randomised and directed checks of serial_alu against a word-level reference model.
module tb_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } resp_t;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Word-level reference: whole-operand arithmetic straight from the operation rules
  function automatic resp_t model(input logic [3:0] ctrl, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    logic [W-1:0] ae;
    logic [W-1:0] be;
    logic [W:0]   s;
    logic         ovf;
    resp_t        e;
    ae  = ctrl[3] ? ~a : a;
    be  = ctrl[2] ? ~b : b;
    s   = {1'b0, ae} + {1'b0, be} + {{W{1'b0}}, ctrl[2]};
    ovf = (ae[W-1] == be[W-1]) && (s[W-1] != ae[W-1]);
    e   = '0;
    case (ctrl[1:0])
      2'b00: e.res = ae & be;
      2'b01: e.res = ae | be;
      2'b10: begin
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = ovf;
      end
      default: e.res = {{(W-1){1'b0}}, s[W-1] ^ ovf};
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic resp_t observed();
    return {result, zero, cout, overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for acceptance, then count edges until out_valid (bounded)
  task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int n;
    n        = 0;
    alu_ctrl = ctrl;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    src1     = $urandom;
    src2     = $urandom;
    alu_ctrl = 4'($urandom);
    lat      = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [3:0]   c_tab [8];
    logic [W-1:0] a_tab [8];
    logic [W-1:0] b_tab [8];
    logic [W-1:0] r_tab [8];
    resp_t        exp_r;
    resp_t        got;
    int           lat;
    c_tab = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100, 4'b1101, 4'b0000, 4'b0001};
    a_tab = '{32'h7FFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
              32'h0F0F_0000, 32'hFFFF_FFFF, 32'hF0F0_FFFF, 32'h1234_0000};
    b_tab = '{32'h0000_0001, 32'h0000_0005, 32'h0000_0001, 32'h8000_0000,
              32'h0000_0F0F, 32'hFFFF_FFFF, 32'hFF00_F00F, 32'h0000_5678};
    r_tab = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
              32'hF0F0_F0F0, 32'h0000_0000, 32'hF000_F00F, 32'h1234_5678};
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(c_tab[i], a_tab[i], b_tab[i], lat);
      exp_r = model(c_tab[i], a_tab[i], b_tab[i]);
      got   = observed();
      n_tests++;
      if (lat !== W + 1) begin
        n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, W + 1);
      end
      n_tests++;
      if (got !== exp_r) begin
        n_fail++; $display("FAIL dir%0d_resp got %h/%b%b%b want %h/%b%b%b", i, got.res, got.z,
                           got.c, got.v, exp_r.res, exp_r.z, exp_r.c, exp_r.v);
      end
      n_tests++;
      if (result !== r_tab[i]) begin
        n_fail++; $display("FAIL dir%0d_result got %h want %h", i, result, r_tab[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [3:0]   codes [7];
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    resp_t        exp_r;
    resp_t        got;
    int           lat;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    for (int i = 0; i < 60; i++) begin
      c = (i % 5 == 4) ? 4'($urandom) : codes[$urandom_range(0, 6)];
      a = $urandom;
      b = (i % 7 == 3) ? a : $urandom;
      issue(c, a, b, lat);
      exp_r = model(c, a, b);
      got   = observed();
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_timeout got out_valid=%b want 1", i, out_valid);
      end
      n_tests++;
      if (got !== exp_r) begin
        n_fail++; $display("FAIL rand%0d_resp ctrl=%b a=%h b=%h got %h/%b%b%b want %h/%b%b%b", i,
                           c, a, b, got.res, got.z, got.c, got.v, exp_r.res, exp_r.z, exp_r.c,
                           exp_r.v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    resp_t        exp_r;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom)};
      a = $urandom;
      b = $urandom;
      issue(c, a, b, lat);
      exp_r = model(c, a, b);
      n_tests++;
      if (observed() !== exp_r) begin
        n_fail++; $display("FAIL b2b%0d_resp got %h want %h", i, observed(), exp_r);
      end
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b%0d_busy got in_ready=%b want 0", i, in_ready);
      end
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b%0d_idle got in_ready=%b out_valid=%b want 1 0", i, in_ready,
                           out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    resp_t snap;
    resp_t exp_r;
    int    lat;
    out_ready = 1'b0;
    issue(4'b0010, 32'h1234_5678, 32'h0F0F_0F0F, lat);
    snap  = observed();
    exp_r = model(4'b0010, 32'h1234_5678, 32'h0F0F_0F0F);
    n_tests++;
    if (snap !== exp_r) begin
      n_fail++; $display("FAIL bp_first_resp got %h want %h", snap, exp_r);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      src1     = $urandom;
      src2     = $urandom;
      alu_ctrl = 4'b0010;
      tick();
      n_tests++;
      if (observed() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got %h v=%b r=%b want %h v=1 r=0", i, observed(),
                           out_valid, in_ready, snap);
      end
    end
    src1      = 32'h0000_0009;
    src2      = 32'h0000_0002;
    alu_ctrl  = 4'b0110;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_handshake got in_ready=%b out_valid=%b want 1 0", in_ready,
                         out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_second_accept got in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    exp_r = model(4'b0110, 32'h0000_0009, 32'h0000_0002);
    n_tests++;
    if (lat !== W + 1 || observed() !== exp_r) begin
      n_fail++; $display("FAIL bp_second_resp got lat=%0d %h want lat=%0d %h", lat, observed(),
                         W + 1, exp_r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int lat;
    out_ready = 1'b1;
    alu_ctrl  = 4'b0010;
    src1      = 32'h0000_1000;
    src2      = 32'h0000_0234;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hs got in_ready=%b out_valid=%b want 1 0", in_ready,
                         out_valid);
    end
    n_tests++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got %h want 0", observed());
    end
    rst = 1'b0;
    tick();
    issue(4'b0010, 32'd3, 32'd4, lat);
    n_tests++;
    if (lat !== W + 1 || result !== 32'd7 || zero !== 1'b0) begin
      n_fail++; $display("FAIL midrst_add got lat=%0d result=%h zero=%b want lat=%0d 7 0", lat,
                         result, zero, W + 1);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src1      = '0;
    src2      = '0;
    alu_ctrl  = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
